// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Brief    : MEM/WB pipeline register, load formatting and regfile write port.
//            Optional macro WB_FWD_EN adds the fwd_en/fwd_rw/fwd_data outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwr,
    input  logic [4:0]       mem_rw,
    input  logic [1:0]       mem_wbsel,
    input  logic [2:0]       mem_ldtype,
    input  logic [1:0]       mem_addr_lo,
    input  logic [DW-1:0]    mem_alu,
    input  logic [DW-1:0]    mem_rdata,
    input  logic [DW-1:0]    mem_pc,
    input  logic             mem_ovf,
    output logic             RegWr,
    output logic [4:0]       Rw,
    output logic [DW-1:0]    Busw,
    output logic             Overflow,
    output logic             wb_valid,
    output logic             adel,
`ifdef WB_FWD_EN
    output logic             fwd_en,
    output logic [4:0]       fwd_rw,
    output logic [DW-1:0]    fwd_data,
`endif
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_LD_LB  = 3'b001;
    localparam logic [2:0] c_LD_LBU = 3'b010;
    localparam logic [2:0] c_LD_LH  = 3'b011;
    localparam logic [2:0] c_LD_LHU = 3'b100;

    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_LINK = 2'b10;

    logic [7:0]       lbyte;
    logic [15:0]      lhalf;
    logic [DW-1:0]    ldata;
    logic             misalign;
    logic [DW-1:0]    busw_d;
    logic             adel_d;
    logic             regwr_d;
    logic             ovf_d;

    logic             valid_q;
    logic             regwr_q;
    logic [4:0]       rw_q;
    logic [DW-1:0]    busw_q;
    logic             ovf_q;
    logic             adel_q;
    logic [CNT_W-1:0] retired_q;

    // Write data and write-enable qualification are resolved before the register
    always_comb begin
        case (mem_addr_lo)
            2'd0:    lbyte = mem_rdata[7:0];
            2'd1:    lbyte = mem_rdata[15:8];
            2'd2:    lbyte = mem_rdata[23:16];
            default: lbyte = mem_rdata[31:24];
        endcase
        lhalf = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (mem_ldtype)
            c_LD_LB: begin
                ldata    = {{(DW-8){lbyte[7]}}, lbyte};
                misalign = 1'b0;
            end
            c_LD_LBU: begin
                ldata    = {{(DW-8){1'b0}}, lbyte};
                misalign = 1'b0;
            end
            c_LD_LH: begin
                ldata    = {{(DW-16){lhalf[15]}}, lhalf};
                misalign = mem_addr_lo[0];
            end
            c_LD_LHU: begin
                ldata    = {{(DW-16){1'b0}}, lhalf};
                misalign = mem_addr_lo[0];
            end
            default: begin
                ldata    = mem_rdata;
                misalign = |mem_addr_lo;
            end
        endcase

        case (mem_wbsel)
            c_SEL_LOAD: busw_d = ldata;
            c_SEL_LINK: busw_d = mem_pc + DW'(8);
            default:    busw_d = mem_alu;
        endcase

        adel_d  = mem_valid & (mem_wbsel == c_SEL_LOAD) & misalign;
        regwr_d = mem_valid & mem_regwr & (|mem_rw) & ~adel_d;
        ovf_d   = mem_valid & mem_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            regwr_q   <= 1'b0;
            rw_q      <= 5'd0;
            busw_q    <= '0;
            ovf_q     <= 1'b0;
            adel_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            // A flush retires the departing instruction even while stalled
            if (valid_q && (!stall || flush)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (flush) begin
                valid_q <= 1'b0;
                regwr_q <= 1'b0;
                rw_q    <= 5'd0;
                busw_q  <= '0;
                ovf_q   <= 1'b0;
                adel_q  <= 1'b0;
            end else if (!stall) begin
                valid_q <= mem_valid;
                regwr_q <= regwr_d;
                rw_q    <= mem_rw;
                busw_q  <= busw_d;
                ovf_q   <= ovf_d;
                adel_q  <= adel_d;
            end
        end
    end

    assign RegWr    = regwr_q;
    assign Rw       = rw_q;
    assign Busw     = busw_q;
    assign Overflow = ovf_q;
    assign wb_valid = valid_q;
    assign adel     = adel_q;
    assign retired  = retired_q;

`ifdef WB_FWD_EN
    assign fwd_en   = regwr_q & ~ovf_q;
    assign fwd_rw   = rw_q;
    assign fwd_data = busw_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage (directed plus randomized).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        mem_valid, mem_regwr, mem_ovf;
    logic [4:0]  mem_rw;
    logic [1:0]  mem_wbsel, mem_addr_lo;
    logic [2:0]  mem_ldtype;
    logic [31:0] mem_alu, mem_rdata, mem_pc;
    logic        RegWr, Overflow, wb_valid, adel;
    logic [4:0]  Rw;
    logic [31:0] Busw;
    logic [31:0] retired;
`ifdef WB_FWD_EN
    logic        fwd_en;
    logic [4:0]  fwd_rw;
    logic [31:0] fwd_data;
`endif

    wb_stage #(.DW(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rw(mem_rw),
        .mem_wbsel(mem_wbsel), .mem_ldtype(mem_ldtype), .mem_addr_lo(mem_addr_lo),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc(mem_pc), .mem_ovf(mem_ovf),
        .RegWr(RegWr), .Rw(Rw), .Busw(Busw), .Overflow(Overflow),
        .wb_valid(wb_valid), .adel(adel),
`ifdef WB_FWD_EN
        .fwd_en(fwd_en), .fwd_rw(fwd_rw), .fwd_data(fwd_data),
`endif
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        ovf;
        logic        adel;
    } wb_t;

    wb_t         exp;
    logic [31:0] exp_ret;
    int          n_vec = 0;
    int          n_err = 0;
    wire  [40:0] act = {wb_valid, RegWr, Rw, Busw, Overflow, adel};

    // Reference: what the WB entry should hold for the current MEM inputs
    function automatic wb_t model();
        wb_t         r;
        logic [31:0] b, h, ld;
        logic        mis;
        b   = (mem_rdata >> (8 * mem_addr_lo)) & 32'hFF;
        h   = (mem_addr_lo >= 2) ? (mem_rdata >> 16) : (mem_rdata & 32'hFFFF);
        mis = 1'b0;
        case (mem_ldtype)
            3'd1:    ld = (b >= 128) ? b - 32'd256 : b;
            3'd2:    ld = b;
            3'd3:    begin ld = (h >= 32768) ? h - 32'h10000 : h; mis = (mem_addr_lo % 2) == 1; end
            3'd4:    begin ld = h; mis = (mem_addr_lo % 2) == 1; end
            default: begin ld = mem_rdata; mis = mem_addr_lo != 0; end
        endcase
        r.valid = mem_valid;
        r.rw    = mem_rw;
        r.busw  = (mem_wbsel == 2) ? mem_pc + 32'd8 : (mem_wbsel == 1) ? ld : mem_alu;
        r.adel  = mem_valid && mem_wbsel == 1 && mis;
        r.regwr = mem_valid && mem_regwr && mem_rw != 0 && !r.adel;
        r.ovf   = mem_valid && mem_ovf;
        return r;
    endfunction

    task automatic set_tx(input logic v, input logic wr, input logic [4:0] rw,
                          input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] a,
                          input logic [31:0] al, input logic [31:0] rd,
                          input logic [31:0] p, input logic o);
        mem_valid = v;   mem_regwr = wr; mem_rw = rw; mem_wbsel = sel;
        mem_ldtype = lt; mem_addr_lo = a; mem_alu = al; mem_rdata = rd;
        mem_pc = p;      mem_ovf = o;
    endtask

    task automatic rand_tx();
        set_tx($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom),
               2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 7) == 0);
    endtask

    // One clock: advance the reference at the edge, return 1 time unit later
    task automatic step(input logic st, input logic fl);
        stall = st;
        flush = fl;
        @(posedge clk);
        if (rst_n) begin
            if (exp.valid && (fl || !st)) exp_ret = exp_ret + 1;
            if (fl)       exp = '0;
            else if (!st) exp = model();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0;
        set_tx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp = '0; exp_ret = '0;
        #2;
        n_vec++;
        if (act !== 41'd0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL reset_initial: got %h/%0d expected 0/0", act, retired);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_tx(1, 1, 5'd3 + 5'(i), 0, 0, 0, $urandom, 0, 0, 0);
            step(0, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (act !== 41'd0 || retired !== 32'd0) begin
            n_err++;
            $display("FAIL reset_midstream: got %h/%0d expected 0/0", act, retired);
        end
        @(negedge clk); rst_n = 1'b1;
        exp = '0; exp_ret = '0;
    endtask

    task automatic test_loads();
        set_tx(1, 1, 5, 2'b01, 3'b001, 3, 0, 32'h80FF7F01, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || !RegWr || Rw !== 5'd5 || Busw !== 32'hFFFFFF80) begin
            n_err++;
            $display("FAIL load_lb: got %h expected %h (Busw ffffff80)", act, exp);
        end
        set_tx(1, 1, 5, 2'b01, 3'b010, 3, 0, 32'h80FF7F01, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || !RegWr || Busw !== 32'h00000080) begin
            n_err++;
            $display("FAIL load_lbu: got %h expected %h (Busw 00000080)", act, exp);
        end
        set_tx(1, 1, 6, 2'b01, 3'b011, 1, 0, 32'h12345678, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || adel !== 1'b1 || RegWr !== 1'b0) begin
            n_err++;
            $display("FAIL load_lh_misaligned: got %h expected %h (adel=1 RegWr=0)", act, exp);
        end
        set_tx(1, 1, 6, 2'b01, 3'b100, 2, 0, 32'h9ABC1234, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || Busw !== 32'h00009ABC || adel !== 1'b0) begin
            n_err++;
            $display("FAIL load_lhu: got %h expected %h (Busw 00009abc)", act, exp);
        end
        set_tx(1, 1, 9, 2'b01, 3'b000, 2, 0, 32'hDEADBEEF, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || adel !== 1'b1 || RegWr !== 1'b0) begin
            n_err++;
            $display("FAIL load_lw_misaligned: got %h expected %h (adel=1)", act, exp);
        end
    endtask

    task automatic test_link_zero();
        set_tx(1, 1, 31, 2'b10, 0, 0, 32'h11111111, 0, 32'h00003000, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || Busw !== 32'h00003008 || !RegWr || Rw !== 5'd31) begin
            n_err++;
            $display("FAIL link_jal: got %h expected %h (Busw 00003008)", act, exp);
        end
        set_tx(1, 1, 31, 2'b10, 0, 0, 0, 0, 32'hFFFFFFFC, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || Busw !== 32'h00000004) begin
            n_err++;
            $display("FAIL link_wrap: got %h expected %h (Busw 00000004)", act, exp);
        end
        set_tx(1, 1, 0, 2'b00, 0, 0, 32'hCAFEF00D, 0, 0, 0);
        step(0, 0);
        n_vec++;
        if (act !== exp || RegWr !== 1'b0 || wb_valid !== 1'b1) begin
            n_err++;
            $display("FAIL alu_r0: got %h expected %h (RegWr=0)", act, exp);
        end
    endtask

    task automatic test_overflow();
        set_tx(1, 1, 12, 2'b00, 0, 0, 32'h80000000, 0, 0, 1);
        step(0, 0);
        n_vec++;
        if (act !== exp || Overflow !== 1'b1 || RegWr !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_add: got %h expected %h (Overflow=1 RegWr=1)", act, exp);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] r0;
        set_tx(1, 1, 7, 2'b00, 0, 0, 32'h0BADC0DE, 0, 0, 0);
        step(0, 0);
        r0 = retired;
        for (int i = 0; i < 3; i++) begin
            rand_tx();
            step(1, 0);
            n_vec++;
            if (act !== exp || wb_valid !== 1'b1 || Busw !== 32'h0BADC0DE || retired !== r0) begin
                n_err++;
                $display("FAIL stall_hold: cycle %0d got %h/%0d expected %h/%0d", i, act, retired, exp, r0);
            end
        end
        step(1, 1);
        n_vec++;
        if (act !== exp || wb_valid !== 1'b0 || RegWr !== 1'b0 || retired !== r0 + 1) begin
            n_err++;
            $display("FAIL stall_flush: got %h/%0d expected %h/%0d", act, retired, exp, r0 + 1);
        end
        step(0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_tx();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            n_vec++;
            if (act !== exp || retired !== exp_ret) begin
                n_err++;
                $display("FAIL random[%0d]: got %h/%0d expected %h/%0d", i, act, retired, exp, exp_ret);
            end
`ifdef WB_FWD_EN
            n_vec++;
            if ({fwd_en, fwd_rw, fwd_data} !== {exp.regwr & ~exp.ovf, exp.rw, exp.busw}) begin
                n_err++;
                $display("FAIL random_fwd[%0d]: got %b/%0d/%h expected %b/%0d/%h", i,
                         fwd_en, fwd_rw, fwd_data, exp.regwr & ~exp.ovf, exp.rw, exp.busw);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_link_zero();
        test_overflow();
        test_stall_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back datapath for the 5-stage MIPS pipeline.
- Captures MEM-stage results, selects and formats the write data, and drives the register file write port (RegWr, Rw, Busw, Overflow).
- The register file commits on the falling edge of the same cycle, so a value written here is readable by ID in that cycle.
- Also counts retired instructions and flags misaligned loads.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold WB register contents.
- flush  in  1  insert a bubble into WB.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_regwr  in  1  instruction writes a GPR.
- mem_rw  in  5  destination register number.
- mem_wbsel  in  2  write source: 00 ALU, 01 load, 10 link (pc+8), 11 reserved (treated as ALU).
- mem_ldtype  in  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others behave as LW.
- mem_addr_lo  in  2  effective address bits [1:0].
- mem_alu  in  32  ALU result.
- mem_rdata  in  32  raw data-memory word.
- mem_pc  in  32  instruction PC.
- mem_ovf  in  1  arithmetic overflow of the instruction.
- RegWr  out  1  register file write enable.
- Rw  out  5  register file write index.
- Busw  out  32  register file write data.
- Overflow  out  1  register file write suppress.
- wb_valid  out  1  WB holds a real instruction.
- adel  out  1  misaligned load in WB; the write is suppressed.
- retired  out  CNT_W  count of instructions that left WB.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All WB register fields clear to 0: RegWr=0, Rw=0, Busw=0, Overflow=0, wb_valid=0, adel=0, retired=0.
  - Reset has effect mid-stall or mid-flush; it overrides everything.
- Capture on posedge, priority order:
  - flush=1: wb_valid<=0 and all write controls <=0. Flush wins over stall.
  - else stall=1: all WB fields hold.
  - else: WB fields <= MEM inputs.
- Latency: one cycle from MEM inputs to the write-port outputs. The regfile write lands on the following negedge.
- Outputs are registered, not combinational from MEM inputs.
- Write-data formatting:
  - Formatting is computed on the MEM side; the formatted Busw is registered.
  - Byte lane k = rdata[8k+7:8k], with k = addr_lo (little-endian).
  - Halfword = rdata[15:0] when addr_lo[1]=0, else rdata[31:16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Link: Busw = mem_pc + 8, with 32-bit wrap-around.
- Misalignment:
  - Misaligned means LW with addr_lo≠00, or LH/LHU with addr_lo[0]=1.
  - A misaligned load sets adel=1 and RegWr=0.
  - The adel check applies only when wbsel=01.
- RegWr = wb_valid & regwr & (Rw≠0) & !adel. A write to $0 is never asserted.
- Overflow = the registered mem_ovf & wb_valid. The regfile gates its own write on Overflow; RegWr is not additionally masked by it.
- Retired counter:
  - Increments by 1 on each posedge where WB holds a valid instruction and is not stalled.
  - A stalled instruction counts exactly once.
  - Bubbles do not count.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous stall and flush: behaves as flush. The counter still counts the departing valid instruction.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds outputs:
  - fwd_en (1) = RegWr & !Overflow.
  - fwd_rw (5) = Rw.
  - fwd_data (32) = Busw.
  - These feed the EX-stage forwarding mux.
- When undefined, these ports do not exist, and forwarding relies on the regfile's negedge write only.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; retired=0.
- LB, rdata=0x80FF7F01, addr_lo=3, rw=5 -> next cycle RegWr=1, Rw=5, Busw=0xFFFFFF80. Repeat with LBU -> Busw=0x00000080.
- LH, addr_lo=1 -> adel=1, RegWr=0. LHU, addr_lo=2, rdata=0x9ABC1234 -> Busw=0x00009ABC.
- JAL link, pc=0x00003000, rw=31 -> Busw=0x00003008. ALU write with rw=0 -> RegWr=0.
- ADD with mem_ovf=1 -> Overflow=1, RegWr=1, and regfile content is unchanged.
- Valid instruction, stall for 3 cycles, then flush+stall -> outputs held 3 cycles, then wb_valid=0; retired increases by exactly 1. With WB_FWD_EN defined, fwd_en tracks RegWr&!Overflow.
